// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: aligns stores, formats loads,
// and stalls the pipeline until the memory completes or rejects the access.
module dmem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemREAD,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  sz_q;
  logic [2:0]  f3_q;

  logic        is_wr;
  logic        req;
  logic        illegal;
  logic        err_d;
  logic [1:0]  sz_d;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] rdata_d;

  assign is_wr = (MemWrite != 2'b00);
  assign req   = is_wr | MemREAD;

  // Size code: 0 byte, 1 half, 2 word; a store overrides any load.
  always_comb begin
    sz_d    = 2'd0;
    illegal = 1'b0;
    if (is_wr) begin
      sz_d = MemWrite - 2'd1;
    end else begin
      case (funct3)
        3'b000, 3'b100: sz_d = 2'd0;
        3'b001, 3'b101: sz_d = 2'd1;
        3'b010:         sz_d = 2'd2;
        default:        illegal = 1'b1;
      endcase
    end
  end

  assign err_d = illegal
               | ((sz_d == 2'd1) & addr[0])
               | ((sz_d == 2'd2) & (addr[1:0] != 2'b00));

  assign stall = ((state_q == IDLE) & req) | (state_q == ACCESS);

  assign mem_we   = we_q;
  assign mem_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = wdata_q;
    if (we_q) begin
      case (sz_q)
        2'd0: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  assign lb = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lh = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    rdata_d = mem_rdata;
    case (f3_q)
      3'b000:  rdata_d = {{24{lb[7]}}, lb};
      3'b100:  rdata_d = {24'd0, lb};
      3'b001:  rdata_d = {{16{lh[15]}}, lh};
      3'b101:  rdata_d = {16'd0, lh};
      default: rdata_d = mem_rdata;
    endcase
    if (we_q) rdata_d = 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      sz_q       <= 2'd0;
      f3_q       <= 3'd0;
      mem_req    <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= is_wr;
            sz_q    <= sz_d;
            f3_q    <= funct3;
            if (err_d) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state_q <= ACCESS;
              mem_req <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_q    <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rdata_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Vector table plus scoreboard bench for dmem_responder.
// Covers lane steering, load extension, waits, errors and reset abort.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemREAD;
  logic [1:0]  MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .MemREAD    (MemREAD),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [1:0]  mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        err;
    logic [31:0] exp_rd;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; leaves it idle at posedge+1.
  task automatic run(input vec_t v);
    exp_t e;
    int   st;
    n_vec++;
    MemREAD   = v.mr;
    MemWrite  = v.mw;
    funct3    = v.f3;
    addr      = v.a;
    wdata     = v.wd;
    mem_rdata = v.rd;
    mem_ready = 1'b0;
    sb.push_back('{err: v.err, rd: v.exp_rd});
    #1;
    chk("idle_stall", 32'(stall), 32'(1));
    chk("idle_req", 32'(mem_req), 32'(0));
    st = int'(stall);
    @(posedge clk); #1;
    MemREAD  = 1'b0;
    MemWrite = 2'b00;
    funct3   = 3'b111;
    addr     = $urandom;
    wdata    = $urandom;
    if (!v.err) begin
      for (int c = 0; c <= v.waits; c++) begin
        chk("acc_req", 32'(mem_req), 32'(1));
        chk("acc_we", 32'(mem_we), 32'(v.we));
        chk("acc_be", 32'(mem_be), 32'(v.be));
        chk("acc_addr", mem_addr, v.maddr);
        if (v.we) chk("acc_wdata", mem_wdata, v.mwd);
        st += int'(stall);
        mem_ready = (c == v.waits);
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
    end
    chk("resp_valid", 32'(resp_valid), 32'(1));
    chk("resp_stall", 32'(stall), 32'(0));
    chk("resp_req", 32'(mem_req), 32'(0));
    chk("stall_cycles", 32'(st), v.err ? 32'(1) : 32'(2 + v.waits));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk("resp_err", 32'(resp_err), 32'(e.err));
      chk("resp_rdata", resp_rdata, e.rd);
      @(posedge clk); #1;
      chk("after_valid", 32'(resp_valid), 32'(0));
      chk("hold_rdata", resp_rdata, e.rd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 2'b01, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0,
                1'b0, 32'h0, 1'b1, 4'b1000, 32'h1000, 32'hABABABAB};
    tbl[1]  = '{1'b1, 2'b00, 3'b000, 32'h2002, 32'h0, 32'h12F45678, 0,
                1'b0, 32'hFFFFFFF4, 1'b0, 4'b1111, 32'h2000, 32'h0};
    tbl[2]  = '{1'b1, 2'b00, 3'b100, 32'h2002, 32'h0, 32'h12F45678, 0,
                1'b0, 32'h000000F4, 1'b0, 4'b1111, 32'h2000, 32'h0};
    tbl[3]  = '{1'b1, 2'b00, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, 3,
                1'b0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h3000, 32'h0};
    tbl[4]  = '{1'b0, 2'b11, 3'b000, 32'h0006, 32'h55, 32'h0, 0,
                1'b1, 32'h0, 1'b1, 4'b1111, 32'h4, 32'h55};
    tbl[5]  = '{1'b1, 2'b11, 3'b010, 32'h0040, 32'h11223344, 32'h55555555, 1,
                1'b0, 32'h0, 1'b1, 4'b1111, 32'h40, 32'h11223344};
    tbl[6]  = '{1'b0, 2'b10, 3'b000, 32'h0102, 32'h0000BEEF, 32'h0, 0,
                1'b0, 32'h0, 1'b1, 4'b1100, 32'h100, 32'hBEEFBEEF};
    tbl[7]  = '{1'b1, 2'b00, 3'b101, 32'h0006, 32'h0, 32'h9ABC1234, 0,
                1'b0, 32'h00009ABC, 1'b0, 4'b1111, 32'h4, 32'h0};
    tbl[8]  = '{1'b1, 2'b00, 3'b001, 32'h0000, 32'h0, 32'h00008765, 2,
                1'b0, 32'hFFFF8765, 1'b0, 4'b1111, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 2'b00, 3'b001, 32'h0001, 32'h0, 32'h0, 0,
                1'b1, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 2'b00, 3'b011, 32'h0000, 32'h0, 32'h0, 0,
                1'b1, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 2'b01, 3'b000, 32'h0000, 32'h1234567F, 32'h0, 0,
                1'b0, 32'h0, 1'b1, 4'b0001, 32'h0, 32'h7F7F7F7F};
    tbl[12] = '{1'b1, 2'b00, 3'b000, 32'h0007, 32'h0, 32'h80FFFFFF, 0,
                1'b0, 32'hFFFFFF80, 1'b0, 4'b1111, 32'h4, 32'h0};

    rst       = 1'b1;
    MemREAD   = 1'b0;
    MemWrite  = 2'b00;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #3;
    chk("rst_req", 32'(mem_req), 32'(0));
    chk("rst_valid", 32'(resp_valid), 32'(0));
    chk("rst_err", 32'(resp_err), 32'(0));
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run(tbl[i]);

    // Abort an access with reset while memory answers.
    n_vec++;
    MemREAD   = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0500;
    mem_rdata = 32'h13572468;
    @(posedge clk); #1;
    MemREAD = 1'b0;
    chk("abort_req_pre", 32'(mem_req), 32'(1));
    mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("abort_req", 32'(mem_req), 32'(0));
    chk("abort_stall", 32'(stall), 32'(0));
    chk("abort_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("abort_valid", 32'(resp_valid), 32'(0));
    chk("abort_addr", mem_addr, 32'h0);
    rst       = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("post_valid", 32'(resp_valid), 32'(0));
    run('{1'b1, 2'b00, 3'b001, 32'h0002, 32'h0, 32'h8001ABCD, 0,
          1'b0, 32'hFFFF8001, 1'b0, 4'b1111, 32'h0, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports `clk` and `rst`.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `rst`  input  1  asynchronous active-high reset.
REQ-004 `MemREAD`  input  1  load request from the MEM stage.
REQ-005 `MemWrite`  input  2  store request: 2'b00 = WRITE_IDLE, 2'b01 = WRITE_BYTE, 2'b10 = WRITE_HALF, 2'b11 = WRITE_WORD.
REQ-006 `funct3`  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 `addr`  input  32  byte address.
REQ-008 `wdata`  input  32  store data, right-aligned.
REQ-009 `stall`  output  1  the pipeline holds the MEM stage while this is high.
REQ-010 `resp_valid`  output  1  one-cycle completion pulse.
REQ-011 `resp_rdata`  output  32  extended load result.
REQ-012 `resp_err`  output  1  misaligned or illegal access; qualified by `resp_valid`.
REQ-013 `mem_req`  output  1  memory access request.
REQ-014 `mem_we`  output  1  1 = write, 0 = read.
REQ-015 `mem_be`  output  4  byte enables; bit i covers bits [8i+7:8i].
REQ-016 `mem_addr`  output  32  word address, with bits [1:0] always 0.
REQ-017 `mem_wdata`  output  32  lane-replicated store data.
REQ-018 `mem_ready`  input  1  memory completes the access in the cycle this is high.
REQ-019 `mem_rdata`  input  32  read word, valid when `mem_ready` is high.

Function
REQ-020 The FSM SHALL have three states:
- IDLE
- ACCESS
- RESP
REQ-021 A request SHALL be present when `MemREAD` = 1 or `MemWrite` != 00; if both are present, the write SHALL win and the read SHALL be ignored.
REQ-022 In IDLE with a request present, `stall` SHALL be 1 combinationally.
REQ-023 On the next edge after REQ-022, the FSM SHALL latch the following and go to ACCESS:
- addr
- wdata
- access type
- funct3
REQ-024 Alignment SHALL be checked against `addr` as follows:
- Half access (SH, LH, LHU) with addr[0] = 1 is misaligned.
- Word access (SW, LW) with addr[1:0] != 00 is misaligned.
- Load `funct3` of 011, 110 or 111 is illegal.
REQ-025 A misaligned or illegal request in IDLE SHALL go directly to RESP with `resp_err` = 1 and `resp_rdata` = 0; it SHALL never assert `mem_req`.
REQ-026 In ACCESS:
- `mem_req` = 1 and `stall` = 1.
- The `mem_*` outputs SHALL be driven from latched values and held stable until `mem_ready`.
- On the edge where `mem_ready` = 1, the FSM SHALL capture the formatted `mem_rdata` and go to RESP.
REQ-027 In RESP:
- `resp_valid` = 1, `stall` = 0, `mem_req` = 0.
- The next state SHALL be IDLE unconditionally; no new request is sampled in RESP.
REQ-028 Minimum latency SHALL be 3 cycles: IDLE accept, ACCESS with `mem_ready` = 1, then RESP; `stall` is high for exactly the first 2 of these cycles.
REQ-029 Each additional `mem_ready` = 0 cycle in ACCESS SHALL add exactly one stall cycle, with no timeout.
REQ-030 Store lanes (little-endian) SHALL be:
- Byte: `mem_be` = 4'b0001 << addr[1:0]; `mem_wdata` = wdata[7:0] replicated ×4.
- Half: `mem_be` = 0011 when addr[1] = 0, 1100 when addr[1] = 1; `mem_wdata` = wdata[15:0] replicated ×2.
- Word: `mem_be` = 1111; `mem_wdata` = wdata.
REQ-031 For reads, `mem_be` SHALL be 1111 and `mem_we` SHALL be 0.
REQ-032 Loads SHALL select their lane by latched addr[1:0]:
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW passes the word through.
REQ-033 For stores, `resp_rdata` SHALL be 0.
REQ-034 `resp_rdata` and `resp_err` SHALL be registered and hold their value until the next RESP.
REQ-035 Inputs SHALL be ignored outside IDLE.

Reset
REQ-036 Asserting `rst` SHALL immediately (asynchronously) force the following:
- state = IDLE
- `mem_req` = 0
- `resp_valid` = 0
- `resp_err` = 0
- `resp_rdata` = 0
- all latched request registers = 0
REQ-037 After REQ-036, `stall` SHALL reflect only the combinational IDLE term.
REQ-038 Reset during ACCESS SHALL abandon the access; a `mem_ready` arriving while `rst` is high SHALL be ignored.
REQ-039 After `rst` deasserts, the first accepted request SHALL behave exactly as from power-up.

Verification
REQ-040 The bench SHALL cover SB at addr 0x1003 with wdata 0xAB, `mem_ready` = 1 immediately. Required: `mem_be` = 1000, `mem_wdata` = 0xABABABAB, `mem_addr` = 0x1000, `stall` high for 2 cycles, `resp_valid` high on cycle 3.
REQ-041 The bench SHALL cover LB at addr 0x2002 with `mem_rdata` = 0x12F45678. Required: `resp_rdata` = 0xFFFFFFF4. Repeat as LBU; required: `resp_rdata` = 0x000000F4.
REQ-042 The bench SHALL cover LW with `mem_ready` low for 3 cycles. Required: `stall` high for 5 cycles, `mem_addr` and `mem_be` constant throughout, then `resp_valid` asserts.
REQ-043 The bench SHALL cover SW at addr 0x0006. Required: no `mem_req` ever, RESP on the next cycle with `resp_err` = 1, `stall` high for 1 cycle.
REQ-044 The bench SHALL cover `rst` asserted mid-ACCESS. Required: `mem_req` drops in the same cycle, state is IDLE, and a following LH at 0x0002 with `mem_rdata` = 0x8001xxxx returns 0xFFFF8001.
REQ-045 The bench SHALL cover `MemREAD` = 1 together with `MemWrite` = 11. Required: a write is performed (`mem_we` = 1) and `resp_rdata` = 0.
